shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle variable-amount shift controller built around a fixed single-step shift datapath (shift by 3 or by 1 per cycle).
- Accepts an operand, a shift amount and an operation over a valid/ready handshake, then sequences the steps.
- Returns the result over a second valid/ready handshake.
- Sits between the ALU issue logic and the shift datapath; replaces a full barrel shifter where area matters.

Parameters:
- Nbits, 32, operand/result width.
- AmtBits, $clog2(Nbits) (5), shift-amount width.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- InValid  input  1  request valid.
- InReady  output  1  sequencer can accept a request.
- InData  input  Nbits  operand, signed.
- InAmt  input  AmtBits  shift amount, 0..Nbits-1.
- InOp  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (ROR only with the macro).
- OutValid  output  1  result valid.
- OutReady  input  1  consumer accepts the result.
- OutData  output  Nbits  shifted result.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high): state IDLE, InReady=1, OutValid=0, OutData=0, Busy=0, internal remaining count=0, internal op=SLL. Reset mid-operation aborts; no result is produced.
- States and transitions:
  - IDLE: InReady=1. On InValid&&InReady, latch InData, InAmt and InOp. Go to DONE if InAmt==0, else RUN.
  - RUN: InReady=0. Each cycle applies one step to the working register:
    - remaining>=3: shift by 3, remaining-=3.
    - remaining in 1..2: shift by 1, remaining-=1.
    - Go to DONE on the cycle in which remaining reaches 0.
  - DONE: OutValid=1, OutData=working register. On OutReady, go to IDLE.
  - OutData and OutValid hold stable while OutValid && !OutReady.
- Step semantics:
  - SLL fills vacated bits with 0.
  - SRL fills vacated bits with 0.
  - SRA fills vacated bits with the MSB of the current working value, so the sign is preserved across steps.
- Latency: for amount A, q=A/3 and r=A%3, so steps n=q+r. OutValid rises n+1 cycles after the accept edge (A=0: 1 cycle; A=31: 12 cycles).
- Throughput: one request in flight. No IDLE bypass, so DONE->IDLE costs one cycle before the next accept.
- InAmt >= Nbits (non-power-of-2 Nbits only): saturate to Nbits-1.
- InValid while busy is ignored. The requester holds its request until InReady.

Optional Feature:
- Macro: SHIFT_SEQ_ROTATE_EN.
- Defined: InOp=11 is rotate-right; vacated MSBs are filled with the bits shifted out, in both step sizes.
- Undefined: InOp=11 executes as SRL; no rotate logic is synthesized.

Decomposition:
- Package shift_seq_pkg:
  - op enum (OP_SLL, OP_SRL, OP_SRA, OP_ROR).
  - state enum (IDLE, RUN, DONE).
  - step constants STEP_BIG=3, STEP_SMALL=1.
- Sub-module shift_step (combinational): inputs are the working value, op and a step-size select; output is the value shifted by 3 or by 1. The FSM and counters stay in shift_sequencer.

Test Plan:
- SRA, InData=0x80000000, InAmt=7 -> steps 3,3,1; OutValid 4 cycles after accept; OutData=0xFF000000.
- SRL, InData=0x80000000, InAmt=4 -> steps 3,1; OutData=0x08000000 after 3 cycles. SLL, InData=0x00000001, InAmt=31 -> OutData=0x80000000, OutValid after 12 cycles.
- InAmt=0, InData=0x12345678, any op -> OutData=0x12345678, OutValid 1 cycle after accept.
- Backpressure: hold OutReady=0 for 5 cycles in DONE -> OutData and OutValid stable; InReady=0 and a new InValid is ignored. Release OutReady -> IDLE next cycle, then a new request is accepted.
- Reset asserted mid-RUN (SRA by 20, after 2 steps) -> all outputs at reset values immediately. After release, a fresh SRL 0xF0000000 by 1 gives 0x78000000.
- With SHIFT_SEQ_ROTATE_EN: ROR, InData=0x00000001, InAmt=4 -> 0x10000000. Without the macro, the same stimulus gives 0x00000000 (executed as SRL).

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and step constants for the multi-cycle shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned STEP_BIG   = 3;
  localparam int unsigned STEP_SMALL = 1;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts by STEP_BIG or STEP_SMALL.
// Rotate-right support is compiled in only with SHIFT_SEQ_ROTATE_EN.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int Nbits = 32
) (
  input  logic [Nbits-1:0] i_val,
  input  op_t              i_op,
  input  logic             i_big,
  output logic [Nbits-1:0] o_val
);

  logic [Nbits-1:0] w_sll;
  logic [Nbits-1:0] w_srl;
  logic [Nbits-1:0] w_sra;

  assign w_sll = i_big ? {i_val[Nbits-1-STEP_BIG:0], {STEP_BIG{1'b0}}}
                       : {i_val[Nbits-1-STEP_SMALL:0], {STEP_SMALL{1'b0}}};
  assign w_srl = i_big ? {{STEP_BIG{1'b0}}, i_val[Nbits-1:STEP_BIG]}
                       : {{STEP_SMALL{1'b0}}, i_val[Nbits-1:STEP_SMALL]};
  assign w_sra = i_big ? {{STEP_BIG{i_val[Nbits-1]}}, i_val[Nbits-1:STEP_BIG]}
                       : {{STEP_SMALL{i_val[Nbits-1]}}, i_val[Nbits-1:STEP_SMALL]};

`ifdef SHIFT_SEQ_ROTATE_EN
  logic [Nbits-1:0] w_ror;
  assign w_ror = i_big ? {i_val[STEP_BIG-1:0], i_val[Nbits-1:STEP_BIG]}
                       : {i_val[STEP_SMALL-1:0], i_val[Nbits-1:STEP_SMALL]};
`endif

  always_comb begin
    o_val = w_srl;
    case (i_op)
      OP_SLL:  o_val = w_sll;
      OP_SRA:  o_val = w_sra;
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROR:  o_val = w_ror;
`endif
      default: o_val = w_srl;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Variable-amount shift controller sequencing 3-bit and 1-bit steps over
// valid/ready handshakes. Optional rotate via SHIFT_SEQ_ROTATE_EN.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int Nbits   = 32,
  parameter int AmtBits = $clog2(Nbits)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [Nbits-1:0]   i_in_data,
  input  logic [AmtBits-1:0] i_in_amt,
  input  logic [1:0]         i_in_op,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [Nbits-1:0]   o_out_data,
  output logic               o_busy
);

  state_t             r_state;
  op_t                r_op;
  logic [Nbits-1:0]   r_work;
  logic [AmtBits-1:0] r_rem;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [Nbits-1:0]   r_out_data;
  logic               r_busy;

  logic               w_big;
  logic [AmtBits-1:0] w_rem_next;
  logic [AmtBits-1:0] w_amt;
  logic [Nbits-1:0]   w_step;

  // Amounts beyond Nbits-1 are only reachable when Nbits is not a power of 2.
  assign w_amt = ({1'b0, i_in_amt} >= (AmtBits+1)'(Nbits)) ? AmtBits'(Nbits-1) : i_in_amt;

  assign w_big      = (r_rem >= AmtBits'(STEP_BIG));
  assign w_rem_next = r_rem - (w_big ? AmtBits'(STEP_BIG) : AmtBits'(STEP_SMALL));

  shift_step #(.Nbits(Nbits)) u_step (
    .i_val (r_work),
    .i_op  (r_op),
    .i_big (w_big),
    .o_val (w_step)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_op        <= OP_SLL;
      r_work      <= '0;
      r_rem       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid && r_in_ready) begin
            r_work     <= i_in_data;
            r_rem      <= w_amt;
            r_op       <= op_t'(i_in_op);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= (w_amt == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          r_work <= w_step;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) r_state <= DONE;
        end
        DONE: begin
          // First DONE cycle registers the result; it then holds until taken.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_work;
          end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: driver pushes expected results,
// monitor pops and compares on each new output, with randomized backpressure.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_amt = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  shift_sequencer #(.Nbits(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .i_in_amt    (in_amt),
    .i_in_op     (in_op),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   bp_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
  endtask

  // Reference: whole-amount shift in one operation.
  function automatic logic [31:0] ref_res(input logic [31:0] d, input int a, input logic [1:0] op);
    logic signed [31:0] sd;
    sd = d;
    case (op)
      2'b00: return d << a;
      2'b01: return d >> a;
      2'b10: return sd >>> a;
      default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
        return (d >> a) | (d << (32 - a));
`else
        return d >> a;
`endif
      end
    endcase
  endfunction

  task automatic send(input logic [31:0] d, input int a, input logic [1:0] op, input bit push);
    int t;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a[4:0];
    in_op    = op;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (push) begin
      e.data = ref_res(d, a, op);
      e.lat  = a / 3 + a % 3 + 1;
      e.acc  = cyc;
      q.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((q.size() != 0 || busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compares new results, checks hold under backpressure, drives ready.
  initial begin
    logic        prev_v;
    logic        prev_r;
    logic [31:0] prev_d;
    int          hold;
    exp_t        e;
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_d = '0;
    hold   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v    = 1'b0;
        prev_r    = 1'b0;
        hold      = 0;
        out_ready = 1'b0;
      end else begin
        if (prev_v && !prev_r) begin
          chk("hold_valid", {31'd0, out_valid}, 32'd1);
          chk("hold_data", out_data, prev_d);
        end else if (prev_v && prev_r) begin
          chk("valid_drop", {31'd0, out_valid}, 32'd0);
        end else if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("data", out_data, e.data);
            chk("latency", cyc - e.acc, e.lat);
            hold   = bp_req;
            bp_req = 0;
          end
        end
        if (out_valid && hold > 0) begin
          chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
          chk("bp_busy", {31'd0, busy}, 32'd1);
        end
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else begin
          out_ready = ($urandom_range(3) != 0);
        end
        prev_v = out_valid;
        prev_r = out_ready;
        prev_d = out_data;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    send(32'h8000_0000, 7, 2'b10, 1'b1);
    send(32'h8000_0000, 4, 2'b01, 1'b1);
    send(32'h0000_0001, 31, 2'b00, 1'b1);
    for (int op = 0; op < 4; op++) send(32'h1234_5678, 0, op[1:0], 1'b1);
    send(32'h0000_0001, 4, 2'b11, 1'b1);

    wait_drain();
    bp_req = 5;
    send(32'hC0DE_F00D, 9, 2'b10, 1'b1);
    send(32'h0F0F_0F0F, 2, 2'b00, 1'b1);

    for (int i = 0; i < 40; i++)
      send($urandom, int'($urandom_range(31)), 2'($urandom_range(3)), 1'b1);

    wait_drain();
    send(32'h8765_4321, 20, 2'b10, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(32'hF000_0000, 1, 2'b01, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
